// File: rtl/ram_probe_ctrl.sv
// RAM exerciser/inspector for the DE10-Lite: debounced write key, single-address pattern write,
// whole-RAM fill/verify sweep with saturating error count, and a paged hex view of one RAM word.
module ram_probe_ctrl #(
    parameter int          DATA_W          = 32,
    parameter int          ADDR_W          = 8,
    parameter int          NUM_DIGITS      = 6,
    parameter int          RD_LATENCY      = 1,
    parameter int          DEBOUNCE_CYCLES = 500000,
    parameter logic [31:0] PATTERN         = 32'h42424242
) (
    input  logic                    MAX10_CLK1_50,
    input  logic                    reset,
    input  logic                    key_write,
    input  logic [9:0]              sw,
    output logic [ADDR_W-1:0]       ram_address,
    output logic [DATA_W-1:0]       ram_data_in,
    output logic                    ram_wren,
    input  logic [DATA_W-1:0]       ram_q,
    output logic [8*NUM_DIGITS-1:0] hex_out,
    output logic [9:0]              led_out
);

    localparam int                    CNT_W     = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam int                    NIBBLES   = DATA_W / 4;
    localparam logic [DATA_W-1:0]     PAT_W     = DATA_W'(PATTERN);
    localparam logic [ADDR_W-1:0]     ADDR_LAST = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0]     ADDR_ONE  = ADDR_W'(1'b1);
    localparam logic [RD_LATENCY-1:0] TAIL_BIT  = RD_LATENCY'(1'b1) << (RD_LATENCY - 1);
    localparam logic [6:0]            ERR_MAX   = 7'h7F;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SWRITE = 3'd1,
        S_FILL   = 3'd2,
        S_VERIFY = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    function automatic logic [6:0] seg_glyph(input logic [3:0] n);
        logic [6:0] g;
        case (n)
            4'h0:    g = 7'h40;
            4'h1:    g = 7'h79;
            4'h2:    g = 7'h24;
            4'h3:    g = 7'h30;
            4'h4:    g = 7'h19;
            4'h5:    g = 7'h12;
            4'h6:    g = 7'h02;
            4'h7:    g = 7'h78;
            4'h8:    g = 7'h00;
            4'h9:    g = 7'h10;
            4'hA:    g = 7'h08;
            4'hB:    g = 7'h03;
            4'hC:    g = 7'h46;
            4'hD:    g = 7'h21;
            4'hE:    g = 7'h06;
            4'hF:    g = 7'h0E;
            default: g = 7'h7F;
        endcase
        return g;
    endfunction

    function automatic logic [3:0] nibble_at(input logic [DATA_W-1:0] w, input int idx);
        logic [DATA_W-1:0] sh;
        sh = w >> (4 * idx);
        return sh[3:0];
    endfunction

    logic [CNT_W-1:0]  db_cnt_q, db_cnt_d;
    logic              db_lvl_q, db_lvl_d;
    logic              db_prev_q;
    logic              press_s;

    state_t            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_inc_s;
    logic [DATA_W-1:0] wdata_q;
    logic              wren_q;
    logic [DATA_W-1:0] disp_q;
    logic              busy_q, pass_q, fail_q;
    logic [6:0]        err_q, err_next_s;
    logic              issuing_q, issue_s;
    logic [RD_LATENCY-1:0] vld_q;
    logic [DATA_W-1:0] exp_q [RD_LATENCY];
    logic              mismatch_s, last_cmp_s;

    // Debounce next state: any low sample restarts the count and drops the level.
    always_comb begin
        db_cnt_d = db_cnt_q;
        db_lvl_d = db_lvl_q;
        if (!key_write) begin
            db_cnt_d = '0;
            db_lvl_d = 1'b0;
        end else if (db_cnt_q == CNT_LAST) begin
            db_lvl_d = 1'b1;
        end else begin
            db_cnt_d = db_cnt_q + CNT_W'(1'b1);
        end
    end

    // Debounce state registers.
    always_ff @(posedge MAX10_CLK1_50) begin
        if (reset) begin
            db_cnt_q  <= '0;
            db_lvl_q  <= 1'b0;
            db_prev_q <= 1'b0;
        end else begin
            db_cnt_q  <= db_cnt_d;
            db_lvl_q  <= db_lvl_d;
            db_prev_q <= db_lvl_q;
        end
    end

    assign press_s    = db_lvl_q & ~db_prev_q;
    assign addr_inc_s = addr_q + ADDR_ONE;
    assign issue_s    = (state_q == S_VERIFY) && issuing_q;

    // The oldest stage of the expected-value pipeline lines up with ram_q.
    assign mismatch_s = vld_q[RD_LATENCY-1] && (ram_q != exp_q[RD_LATENCY-1]);
    assign last_cmp_s = (state_q == S_VERIFY) && !issuing_q && (vld_q == TAIL_BIT);

    // Saturating error count update for the compare happening this cycle.
    always_comb begin
        if (mismatch_s && (err_q != ERR_MAX)) begin
            err_next_s = err_q + 7'd1;
        end else begin
            err_next_s = err_q;
        end
    end

    // Main controller: address/data/enable sequencing, compare pipeline and status registers.
    always_ff @(posedge MAX10_CLK1_50) begin
        if (reset) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            wren_q    <= 1'b0;
            disp_q    <= '0;
            busy_q    <= 1'b0;
            pass_q    <= 1'b0;
            fail_q    <= 1'b0;
            err_q     <= 7'd0;
            issuing_q <= 1'b0;
            vld_q     <= '0;
            for (int k = 0; k < RD_LATENCY; k++) begin
                exp_q[k] <= '0;
            end
        end else begin
            vld_q    <= (vld_q << 1) | RD_LATENCY'(issue_s);
            exp_q[0] <= PAT_W ^ DATA_W'(addr_q);
            for (int k = 1; k < RD_LATENCY; k++) begin
                exp_q[k] <= exp_q[k-1];
            end

            case (state_q)
                S_IDLE: begin
                    wren_q <= 1'b0;
                    disp_q <= ram_q;
                    if (press_s && !sw[9]) begin
                        addr_q  <= sw[ADDR_W-1:0];
                        wdata_q <= PAT_W;
                        wren_q  <= 1'b1;
                        state_q <= S_SWRITE;
                    end else if (press_s && sw[9]) begin
                        addr_q  <= '0;
                        wdata_q <= PAT_W;
                        wren_q  <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= S_FILL;
                    end else begin
                        addr_q <= sw[ADDR_W-1:0];
                    end
                end

                S_SWRITE: begin
                    wren_q  <= 1'b0;
                    addr_q  <= sw[ADDR_W-1:0];
                    state_q <= S_IDLE;
                end

                S_FILL: begin
                    if (addr_q == ADDR_LAST) begin
                        wren_q    <= 1'b0;
                        err_q     <= 7'd0;
                        addr_q    <= '0;
                        issuing_q <= 1'b1;
                        state_q   <= S_VERIFY;
                    end else begin
                        addr_q  <= addr_inc_s;
                        wdata_q <= PAT_W ^ DATA_W'(addr_inc_s);
                        wren_q  <= 1'b1;
                    end
                end

                S_VERIFY: begin
                    wren_q <= 1'b0;
                    err_q  <= err_next_s;
                    if (issuing_q) begin
                        if (addr_q == ADDR_LAST) begin
                            issuing_q <= 1'b0;
                        end else begin
                            addr_q <= addr_inc_s;
                        end
                    end
                    if (last_cmp_s) begin
                        busy_q  <= 1'b0;
                        pass_q  <= (err_next_s == 7'd0);
                        fail_q  <= (err_next_s != 7'd0);
                        disp_q  <= DATA_W'(err_next_s);
                        state_q <= S_DONE;
                    end
                end

                S_DONE: begin
                    wren_q <= 1'b0;
                    if (press_s) begin
                        pass_q  <= 1'b0;
                        fail_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end

                default: begin
                    wren_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign ram_address = addr_q;
    assign ram_data_in = wdata_q;
    assign ram_wren    = wren_q;
    assign led_out     = {busy_q, pass_q, fail_q, err_q};

    // Page p shows nibbles p*NUM_DIGITS.. ; digits past the word width are dark.
    for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_digit
        localparam int IDX_P0 = d;
        localparam int IDX_P1 = NUM_DIGITS + d;

        logic [3:0] nib_s;
        logic       vis_s;
        logic       dp_n_s;
        logic [7:0] digit_s;

        // Per-digit nibble select and glyph decode.
        always_comb begin
            nib_s  = 4'h0;
            vis_s  = 1'b0;
            dp_n_s = 1'b1;
            if (sw[8]) begin
                nib_s  = nibble_at(disp_q, IDX_P1);
                vis_s  = (IDX_P1 < NIBBLES);
                dp_n_s = (d != 0);
            end else begin
                nib_s  = nibble_at(disp_q, IDX_P0);
                vis_s  = (IDX_P0 < NIBBLES);
                dp_n_s = 1'b1;
            end
            if (vis_s) begin
                digit_s = {dp_n_s, seg_glyph(nib_s)};
            end else begin
                digit_s = 8'hFF;
            end
        end

        assign hex_out[8*d +: 8] = digit_s;
    end

endmodule

// File: tb/tb_ram_probe_ctrl.sv
// Self-checking bench for ram_probe_ctrl: two instances (read latency 1 and 3) share stimulus,
// each with its own behavioural RAM; writes are scoreboarded, status/display checked by table.
module tb_ram_probe_ctrl;

    localparam logic [31:0] PAT = 32'h42424242;

    logic        clk = 1'b0;
    logic        reset;
    logic        key_write;
    logic [9:0]  sw;
    logic [7:0]  addr1, addr3;
    logic [31:0] data1, data3, q1, q3;
    logic        wren1, wren3;
    logic [47:0] hex1, hex3;
    logic [9:0]  led1, led3;

    always #10 clk = ~clk;

    ram_probe_ctrl #(.DATA_W(32), .ADDR_W(8), .NUM_DIGITS(6), .RD_LATENCY(1),
                     .DEBOUNCE_CYCLES(4), .PATTERN(PAT)) u_dut1 (
        .MAX10_CLK1_50(clk), .reset(reset), .key_write(key_write), .sw(sw),
        .ram_address(addr1), .ram_data_in(data1), .ram_wren(wren1), .ram_q(q1),
        .hex_out(hex1), .led_out(led1)
    );

    ram_probe_ctrl #(.DATA_W(32), .ADDR_W(8), .NUM_DIGITS(6), .RD_LATENCY(3),
                     .DEBOUNCE_CYCLES(4), .PATTERN(PAT)) u_dut3 (
        .MAX10_CLK1_50(clk), .reset(reset), .key_write(key_write), .sw(sw),
        .ram_address(addr3), .ram_data_in(data3), .ram_wren(wren3), .ram_q(q3),
        .hex_out(hex3), .led_out(led3)
    );

    // 0: clean reads, 1: flip a bit at 0x10 and 0x80, 2: flip a bit everywhere
    int corrupt_mode = 0;

    function automatic logic [31:0] rd_word(input logic [31:0] w, input logic [7:0] a);
        if (corrupt_mode == 2 || (corrupt_mode == 1 && (a == 8'h10 || a == 8'h80))) begin
            return w ^ 32'h0000_0100;
        end
        return w;
    endfunction

    logic [31:0] mem1 [256];
    logic [31:0] mem3 [256];
    logic [31:0] p3 [3];

    always @(posedge clk) begin
        if (wren1) mem1[addr1] <= data1;
        q1 <= rd_word(mem1[addr1], addr1);
    end

    always @(posedge clk) begin
        if (wren3) mem3[addr3] <= data3;
        p3[0] <= rd_word(mem3[addr3], addr3);
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign q3 = p3[2];

    typedef struct packed {
        logic [7:0]  a;
        logic [31:0] d;
    } wr_t;

    typedef struct {
        logic [9:0]  sw;
        logic [47:0] hex;
    } vec_t;

    wr_t  sb1 [$];
    wr_t  sb3 [$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   wcnt1   = 0;
    int   wcnt3   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic sb_pop(input string name, input logic [7:0] a, input logic [31:0] d,
                          inout wr_t q[$]);
        wr_t e;
        if (q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: unexpected write addr %h data %h, required none", name, a, d);
        end else begin
            e = q.pop_front();
            check(name, {24'h0, a, d}, {24'h0, e.a, e.d});
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (!reset && wren1) begin
            wcnt1++;
            sb_pop("sb1_write", addr1, data1, sb1);
        end
        if (!reset && wren3) begin
            wcnt3++;
            sb_pop("sb3_write", addr3, data3, sb3);
        end
    endtask

    task automatic press(input int hold);
        key_write = 1'b1;
        repeat (hold) tick();
        key_write = 1'b0;
        repeat (2) tick();
    endtask

    task automatic push_fill();
        for (int a = 0; a < 256; a++) begin
            sb1.push_back({8'(a), PAT ^ 32'(a)});
            sb3.push_back({8'(a), PAT ^ 32'(a)});
        end
    endtask

    task automatic wait_done(input string name);
        int k;
        k = 0;
        while (k < 2000 && (led1[9] || led3[9])) begin
            tick();
            k++;
        end
        check(name, 64'(k < 2000), 64'd1);
    endtask

    task automatic check_both(input string name, input logic [9:0] led_req, input logic [47:0] hex_req);
        check({name, "_led1"}, 64'(led1), 64'(led_req));
        check({name, "_led3"}, 64'(led3), 64'(led_req));
        check({name, "_hex1"}, 64'(hex1), 64'(hex_req));
        check({name, "_hex3"}, 64'(hex3), 64'(hex_req));
    endtask

    vec_t vecs [6];

    initial begin
        int w0;
        vecs[0] = '{sw: 10'h07F, hex: 48'h99A499A4B0A1};
        vecs[1] = '{sw: 10'h0FF, hex: 48'h99A499A483A1};
        vecs[2] = '{sw: 10'h000, hex: 48'h99A499A499A4};
        vecs[3] = '{sw: 10'h010, hex: 48'h99A499A492A4};
        vecs[4] = '{sw: 10'h1FF, hex: 48'hFFFFFFFF9924};
        vecs[5] = '{sw: 10'h0A5, hex: 48'h99A499A486F8};

        reset     = 1'b1;
        key_write = 1'b0;
        sw        = 10'h000;
        repeat (3) tick();
        check_both("reset", 10'h000, 48'hC0C0C0C0C0C0);
        check("reset_wren1", 64'(wren1), 64'd0);
        check("reset_addr1", 64'(addr1), 64'd0);
        check("reset_data1", 64'(data1), 64'd0);
        reset = 1'b0;
        tick();

        // Short press is filtered out.
        w0 = wcnt1;
        press(3);
        repeat (8) tick();
        check("short_press_no_write", 64'(wcnt1 - w0), 64'd0);

        // Long held press gives exactly one write.
        sw = 10'h005;
        sb1.push_back({8'h05, PAT});
        sb3.push_back({8'h05, PAT});
        w0 = wcnt1;
        press(10);
        repeat (4) tick();
        check("long_press_one_write", 64'(wcnt1 - w0), 64'd1);
        check("long_press_sb1_empty", 64'(sb1.size()), 64'd0);

        // Single write at 3, then view it on both pages.
        sw = 10'h003;
        sb1.push_back({8'h03, PAT});
        sb3.push_back({8'h03, PAT});
        w0 = wcnt3;
        press(6);
        repeat (8) tick();
        check("single_one_write3", 64'(wcnt3 - w0), 64'd1);
        check("single_addr_idle", 64'(addr1), 64'h03);
        check("single_hex1_p0", 64'(hex1), 64'h99A499A499A4);
        check("single_hex3_p0", 64'(hex3), 64'h99A499A499A4);
        sw = 10'h103;
        repeat (6) tick();
        check("single_hex1_p1", 64'(hex1), 64'hFFFFFFFF9924);
        check("single_hex3_p1", 64'(hex3), 64'hFFFFFFFF9924);

        // Clean fill/verify.
        sw = 10'h200;
        push_fill();
        press(6);
        check("fill_busy", 64'(led1[9]), 64'd1);
        wait_done("fill_clean_done");
        check_both("fill_clean", 10'h100, 48'hC0C0C0C0C0C0);
        check("fill_clean_sb1", 64'(sb1.size()), 64'd0);
        check("fill_clean_sb3", 64'(sb3.size()), 64'd0);

        // Leave DONE and browse the filled RAM.
        press(6);
        check("done_exit_led", 64'(led1), 64'h000);
        for (int i = 0; i < 6; i++) begin
            sw = vecs[i].sw;
            repeat (6) tick();
            check($sformatf("view%0d_hex1", i), 64'(hex1), 64'(vecs[i].hex));
            check($sformatf("view%0d_hex3", i), 64'(hex3), 64'(vecs[i].hex));
        end

        // Two corrupted locations.
        corrupt_mode = 1;
        sw = 10'h200;
        push_fill();
        press(6);
        wait_done("two_err_done");
        check_both("two_err", 10'h082, 48'hC0C0C0C0C0A4);
        press(6);
        check("two_err_after_press_led1", 64'(led1), 64'h002);
        check("two_err_after_press_led3", 64'(led3), 64'h002);

        // Every location corrupted: count saturates.
        corrupt_mode = 2;
        push_fill();
        press(6);
        wait_done("sat_done");
        check_both("sat", 10'h0FF, 48'hC0C0C0C0F88E);
        press(6);

        // Reset in the middle of verify.
        push_fill();
        press(6);
        repeat (300) tick();
        check("mid_verify_busy1", 64'(led1[9]), 64'd1);
        check("mid_verify_busy3", 64'(led3[9]), 64'd1);
        reset = 1'b1;
        tick();
        check("abort_led1", 64'(led1), 64'h000);
        check("abort_led3", 64'(led3), 64'h000);
        check("abort_wren1", 64'(wren1), 64'd0);
        reset = 1'b0;
        repeat (5) tick();
        check("abort_stays_idle", 64'(led1), 64'h000);
        check("abort_sb1", 64'(sb1.size()), 64'd0);

        // Press and switch changes during fill are ignored.
        corrupt_mode = 0;
        sw = 10'h200;
        push_fill();
        press(6);
        repeat (40) tick();
        sw = 10'h0AB;
        press(6);
        sw = 10'h200;
        wait_done("ignore_done");
        check_both("ignore", 10'h100, 48'hC0C0C0C0C0C0);
        check("ignore_sb1", 64'(sb1.size()), 64'd0);
        check("ignore_sb3", 64'(sb3.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
